controlador_esteira_param: RTL and testbench
============================================

# controlador_esteira_param

Parametrised bottling-line controller: sequences one bottle through fill, cork, quality-check and seal/count stations, drives the conveyor motor and actuators, and keeps the cork magazine, cork stock and dozen counters. It is the next generation of the wine-conveyor top-level control. Magazine size, refill threshold, lot size, fill timeout and discard duration are generics. It adds automatic magazine refill from stock, a fill-timeout fault state and a timed discard. It sits after the debounce/clock-enable stage and drives the 7-segment/BCD display path.

## Interface
- ROLHA_MAX, 20: magazine capacity (corks); reset and refill value.
- ROLHA_MIN, 5: refill threshold; refill when magazine < ROLHA_MIN.
- ESTOQUE_INIT, 10: cork boxes in stock after reset (≤255).
- LOTE, 12: bottles per lot ("dúzia").
- DUZIA_MAX, 99: dozen counter saturation value.
- FILL_TIMEOUT, 50: TICKs allowed in ENCHENDO before fault.
- DESCARTE_TICKS, 4: TICKs DESCARTE stays asserted.
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- TICK  in  1  one-CLK slow time-base enable; used only by timers.
- KEY_START, KEY_VEDAR, KEY_ENTER_CQ, KEY_LACRE_CONTA  in  1 each  debounced single-CLK pulses.
- SW_ADD_ROLHA  in  1  single-CLK pulse; adds one box to stock.
- SW_QUALIDADE_OK  in  1  level; sampled on KEY_ENTER_CQ.
- SENSOR_POS_ENCHIMENTO, SENSOR_POS_CQ, SENSOR_POS_LACRE, SENSOR_GARRAFA_CHEIA  in  1 each  levels.
- MOTOR, VALVULA_ENCHIMENTO, DESCARTE, FALHA  out  1 each  Moore outputs decoded from the state register.
- ATUADOR_VEDACAO, DISPENSADOR_ROLHAS  out  1 each  registered single-CLK pulses.
- ALARME_ROLHA  out  1  high when CONT_ROLHAS < ROLHA_MIN and ESTOQUE == 0.
- ESTADO  out  4  state code.
- CONT_ROLHAS  out  $clog2(ROLHA_MAX+1)  corks in magazine.
- ESTOQUE  out  8  boxes in stock.
- CONT_GARRAFAS  out  $clog2(LOTE)  bottles in current lot.
- CONT_DUZIAS  out  7  completed lots.

## Operation
States and codes, with transitions evaluated each CLK:
- IDLE=0: on START with CONT_ROLHAS>0, go to MOVE_ENCH. On START with CONT_ROLHAS==0, stay in IDLE.
- MOVE_ENCH=1: MOTOR=1. On SENSOR_POS_ENCHIMENTO, go to ENCHENDO and clear the timer.
- ENCHENDO=2: VALVULA_ENCHIMENTO=1.
  - Timer increments on each TICK.
  - SENSOR_GARRAFA_CHEIA goes to VEDANDO and has priority over timeout.
  - Timer reaching FILL_TIMEOUT goes to FALHA.
- VEDANDO=3: on VEDAR with CONT_ROLHAS>0, pulse ATUADOR_VEDACAO, decrement CONT_ROLHAS and go to MOVE_CQ. On VEDAR with CONT_ROLHAS==0, ignore the press and stay.
- MOVE_CQ=4: MOTOR=1. On SENSOR_POS_CQ, go to CQ.
- CQ=5: on ENTER_CQ, go to MOVE_LACRE if QUALIDADE_OK, else to DESCARTE with the timer cleared.
- MOVE_LACRE=6: MOTOR=1. On SENSOR_POS_LACRE, go to LACRE.
- LACRE=7: on LACRE_CONTA, do the lot count below, then go to IDLE.
  - CONT_GARRAFAS==LOTE-1: set it to 0 and increment CONT_DUZIAS, saturating at DUZIA_MAX.
  - Otherwise: increment CONT_GARRAFAS.
- DESCARTE=8: DESCARTE=1. After DESCARTE_TICKS TICKs, go to IDLE. Lot counters are unchanged.
- FALHA=9: FALHA=1 and all actuators off. START returns to IDLE; no bottle is counted.
- Unused codes 10–15: return to IDLE next CLK.
- Button pulses not listed for the current state are ignored and not stored.

Refill, independent of the FSM:
- Condition: CONT_ROLHAS<ROLHA_MIN and ESTOQUE>0.
- Action: set CONT_ROLHAS to ROLHA_MAX, decrement ESTOQUE, pulse DISPENSADOR_ROLHAS.
- Same-cycle collision with a seal decrement: the seal wins and the refill waits one cycle.

ADD_ROLHA: ESTOQUE+1, saturating at 255. Coinciding with a refill decrement, ESTOQUE is unchanged that cycle.

## Timing
Reset values:
- State IDLE; CONT_ROLHAS=ROLHA_MAX; ESTOQUE=ESTOQUE_INIT; all other counters and the timer 0.
- Every 1-bit output 0; ESTADO=0.

Reset is asynchronous and can occur mid-operation:
- Outputs change immediately on RESET low.
- Any bottle in progress is abandoned and not counted.

Latencies:
- Sensor/button seen at CLK edge n: state and Moore outputs change after edge n (visible in cycle n+1).
- MOTOR falls in the cycle after the stop sensor is sampled high.
- ATUADOR_VEDACAO and DISPENSADOR_ROLHAS are high for exactly one CLK.
- CONT_ROLHAS updates together with its pulse.
- Refill: starts the CLK after the condition becomes true, unless deferred by the seal collision.
- ENCHENDO timeout: FALHA asserts the CLK after the FILL_TIMEOUT-th TICK.
- DESCARTE: high from entry until the CLK after the DESCARTE_TICKS-th TICK.

## Test plan
- Nominal cycle: START → sensor sequence → VEDAR → ENTER_CQ with OK=1 → LACRE_CONTA. Required: MOTOR high only in states 1, 4 and 6; CONT_ROLHAS 20→19; CONT_GARRAFAS=1; ESTADO returns to 0.
- Lot rollover: 12 nominal cycles. Required: CONT_GARRAFAS 11→0 and CONT_DUZIAS 0→1 on the 12th LACRE_CONTA. Forcing CONT_DUZIAS=99 then completing another lot keeps it at 99.
- Refill/collision: 16 seals. Required: the seal taking CONT_ROLHAS 5→4 is followed next CLK by CONT_ROLHAS=20, ESTOQUE 10→9 and one DISPENSADOR pulse. With ADD_ROLHA in the refill cycle, ESTOQUE stays 10.
- Starvation: ESTOQUE=0 and CONT_ROLHAS=0. Required: ALARME_ROLHA=1; VEDAR ignored in state 3; START ignored in IDLE. ADD_ROLHA then refills the magazine to 20 and clears the alarm.
- Fill timeout with FILL_TIMEOUT=50 and no SENSOR_GARRAFA_CHEIA. Required: FALHA=1 and VALVULA_ENCHIMENTO=0 after the 50th TICK. START → IDLE, counters unchanged.
- Reject and reset: ENTER_CQ with OK=0 → DESCARTE=1 for 4 TICKs, then IDLE with CONT_GARRAFAS unchanged. RESET low during MOVE_LACRE clears MOTOR and ESTADO immediately.

Source files
------------

// File: rtl/controlador_esteira_param.sv
// controlador_esteira_param
// Bottling-line controller. Walks one bottle at a time through the fill,
// cork, quality-check and seal/count stations, drives the conveyor motor
// and the station actuators, and keeps the cork magazine, cork stock and
// lot (dozen) counters. The magazine refills itself from stock.
//
// Ports
//   CLK, RESET (async, active low), TICK (slow time-base enable, timers only)
//   KEY_START, KEY_VEDAR, KEY_ENTER_CQ, KEY_LACRE_CONTA : single-CLK pulses
//   SW_ADD_ROLHA : single-CLK pulse, one box into stock
//   SW_QUALIDADE_OK : level, sampled on KEY_ENTER_CQ
//   SENSOR_* : position / bottle-full levels
//   MOTOR, VALVULA_ENCHIMENTO, DESCARTE, FALHA : Moore outputs of the state
//   ATUADOR_VEDACAO, DISPENSADOR_ROLHAS : registered one-CLK pulses
//   ALARME_ROLHA : magazine low with no stock left
//   ESTADO, CONT_ROLHAS, ESTOQUE, CONT_GARRAFAS, CONT_DUZIAS : status
module controlador_esteira_param #(
  parameter int ROLHA_MAX      = 20,
  parameter int ROLHA_MIN      = 5,
  parameter int ESTOQUE_INIT   = 10,
  parameter int LOTE           = 12,
  parameter int DUZIA_MAX      = 99,
  parameter int FILL_TIMEOUT   = 50,
  parameter int DESCARTE_TICKS = 4
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            TICK,
  input  logic                            KEY_START,
  input  logic                            KEY_VEDAR,
  input  logic                            KEY_ENTER_CQ,
  input  logic                            KEY_LACRE_CONTA,
  input  logic                            SW_ADD_ROLHA,
  input  logic                            SW_QUALIDADE_OK,
  input  logic                            SENSOR_POS_ENCHIMENTO,
  input  logic                            SENSOR_POS_CQ,
  input  logic                            SENSOR_POS_LACRE,
  input  logic                            SENSOR_GARRAFA_CHEIA,
  output logic                            MOTOR,
  output logic                            VALVULA_ENCHIMENTO,
  output logic                            DESCARTE,
  output logic                            FALHA,
  output logic                            ATUADOR_VEDACAO,
  output logic                            DISPENSADOR_ROLHAS,
  output logic                            ALARME_ROLHA,
  output logic [3:0]                      ESTADO,
  output logic [$clog2(ROLHA_MAX+1)-1:0]  CONT_ROLHAS,
  output logic [7:0]                      ESTOQUE,
  output logic [$clog2(LOTE)-1:0]         CONT_GARRAFAS,
  output logic [6:0]                      CONT_DUZIAS
);

  localparam int RW   = $clog2(ROLHA_MAX + 1);
  localparam int GW   = $clog2(LOTE);
  localparam int TMAX = (FILL_TIMEOUT > DESCARTE_TICKS) ? FILL_TIMEOUT : DESCARTE_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_MOVE_ENCH  = 4'd1,
    S_ENCHENDO   = 4'd2,
    S_VEDANDO    = 4'd3,
    S_MOVE_CQ    = 4'd4,
    S_CQ         = 4'd5,
    S_MOVE_LACRE = 4'd6,
    S_LACRE      = 4'd7,
    S_DESCARTE   = 4'd8,
    S_FALHA      = 4'd9
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   rolhas_q, rolhas_d;
  logic [7:0]      estoque_q, estoque_d;
  logic [GW-1:0]   garrafas_q, garrafas_d;
  logic [6:0]      duzias_q, duzias_d;
  logic            atuador_q, atuador_d;
  logic            dispensador_q, dispensador_d;
  logic            seal;
  logic            count_lot;
  logic            refill;

  // Next state, timer, and the one-cycle seal / lot-count strobes.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    seal      = 1'b0;
    count_lot = 1'b0;
    case (state_q)
      S_IDLE:
        if (KEY_START && rolhas_q != '0) state_d = S_MOVE_ENCH;
      S_MOVE_ENCH:
        if (SENSOR_POS_ENCHIMENTO) begin
          state_d = S_ENCHENDO;
          timer_d = '0;
        end
      S_ENCHENDO:
        // A full bottle wins over a timeout landing on the same edge.
        if (SENSOR_GARRAFA_CHEIA) begin
          state_d = S_VEDANDO;
        end else if (TICK) begin
          timer_d = timer_q + TW'(1);
          if (timer_q == TW'(FILL_TIMEOUT - 1)) state_d = S_FALHA;
        end
      S_VEDANDO:
        if (KEY_VEDAR && rolhas_q != '0) begin
          seal    = 1'b1;
          state_d = S_MOVE_CQ;
        end
      S_MOVE_CQ:
        if (SENSOR_POS_CQ) state_d = S_CQ;
      S_CQ:
        if (KEY_ENTER_CQ) begin
          if (SW_QUALIDADE_OK) begin
            state_d = S_MOVE_LACRE;
          end else begin
            state_d = S_DESCARTE;
            timer_d = '0;
          end
        end
      S_MOVE_LACRE:
        if (SENSOR_POS_LACRE) state_d = S_LACRE;
      S_LACRE:
        if (KEY_LACRE_CONTA) begin
          count_lot = 1'b1;
          state_d   = S_IDLE;
        end
      S_DESCARTE:
        if (TICK) begin
          timer_d = timer_q + TW'(1);
          if (timer_q == TW'(DESCARTE_TICKS - 1)) state_d = S_IDLE;
        end
      S_FALHA:
        if (KEY_START) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Magazine, stock and lot counters.
  always_comb begin
    // A seal decrement in this cycle pushes the refill to the next cycle.
    refill = (rolhas_q < RW'(ROLHA_MIN)) && (estoque_q != 8'd0) && !seal;

    rolhas_d = rolhas_q;
    if (seal)        rolhas_d = rolhas_q - RW'(1);
    else if (refill) rolhas_d = RW'(ROLHA_MAX);

    // Add and refill together cancel out.
    estoque_d = estoque_q;
    if (refill && !SW_ADD_ROLHA)                            estoque_d = estoque_q - 8'd1;
    else if (SW_ADD_ROLHA && !refill && estoque_q != 8'hFF) estoque_d = estoque_q + 8'd1;

    garrafas_d = garrafas_q;
    duzias_d   = duzias_q;
    if (count_lot) begin
      if (garrafas_q == GW'(LOTE - 1)) begin
        garrafas_d = '0;
        if (duzias_q != 7'(DUZIA_MAX)) duzias_d = duzias_q + 7'd1;
      end else begin
        garrafas_d = garrafas_q + GW'(1);
      end
    end

    atuador_d     = seal;
    dispensador_d = refill;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      rolhas_q      <= RW'(ROLHA_MAX);
      estoque_q     <= 8'(ESTOQUE_INIT);
      garrafas_q    <= '0;
      duzias_q      <= '0;
      atuador_q     <= 1'b0;
      dispensador_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rolhas_q      <= rolhas_d;
      estoque_q     <= estoque_d;
      garrafas_q    <= garrafas_d;
      duzias_q      <= duzias_d;
      atuador_q     <= atuador_d;
      dispensador_q <= dispensador_d;
    end
  end

  assign MOTOR              = (state_q == S_MOVE_ENCH) || (state_q == S_MOVE_CQ) ||
                              (state_q == S_MOVE_LACRE);
  assign VALVULA_ENCHIMENTO = (state_q == S_ENCHENDO);
  assign DESCARTE           = (state_q == S_DESCARTE);
  assign FALHA              = (state_q == S_FALHA);
  assign ATUADOR_VEDACAO    = atuador_q;
  assign DISPENSADOR_ROLHAS = dispensador_q;
  assign ALARME_ROLHA       = (rolhas_q < RW'(ROLHA_MIN)) && (estoque_q == 8'd0);
  assign ESTADO             = state_q;
  assign CONT_ROLHAS        = rolhas_q;
  assign ESTOQUE            = estoque_q;
  assign CONT_GARRAFAS      = garrafas_q;
  assign CONT_DUZIAS        = duzias_q;

endmodule

// File: tb/tb_controlador_esteira_param.sv
// Directed bench for controlador_esteira_param with default parameters.
module tb_controlador_esteira_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 0, key_start = 0, key_vedar = 0, key_cq = 0, key_lacre = 0;
  logic sw_add = 0, sw_ok = 0;
  logic s_ench = 0, s_cq = 0, s_lacre = 0, s_cheia = 0;
  logic motor, valvula, descarte, falha, atuador, dispensador, alarme;
  logic [3:0] estado;
  logic [4:0] cont_rolhas;
  logic [7:0] estoque;
  logic [3:0] cont_garrafas;
  logic [6:0] cont_duzias;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  controlador_esteira_param dut (
    .CLK(clk), .RESET(reset_n), .TICK(tick),
    .KEY_START(key_start), .KEY_VEDAR(key_vedar), .KEY_ENTER_CQ(key_cq),
    .KEY_LACRE_CONTA(key_lacre), .SW_ADD_ROLHA(sw_add), .SW_QUALIDADE_OK(sw_ok),
    .SENSOR_POS_ENCHIMENTO(s_ench), .SENSOR_POS_CQ(s_cq),
    .SENSOR_POS_LACRE(s_lacre), .SENSOR_GARRAFA_CHEIA(s_cheia),
    .MOTOR(motor), .VALVULA_ENCHIMENTO(valvula), .DESCARTE(descarte),
    .FALHA(falha), .ATUADOR_VEDACAO(atuador), .DISPENSADOR_ROLHAS(dispensador),
    .ALARME_ROLHA(alarme), .ESTADO(estado), .CONT_ROLHAS(cont_rolhas),
    .ESTOQUE(estoque), .CONT_GARRAFAS(cont_garrafas), .CONT_DUZIAS(cont_duzias)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
      $display("check %-16s obs=%0d exp=%0d ok", tag, obs, exp);
    end else begin
      $display("FAIL %-16s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, outputs are read there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic to_seal();
    key_start = 1; cyc(); key_start = 0;
    s_ench    = 1; cyc(); s_ench    = 0;
    s_cheia   = 1; cyc(); s_cheia   = 0;
    key_vedar = 1; cyc(); key_vedar = 0;
  endtask

  task automatic finish_cq(input logic ok);
    sw_ok = ok; key_cq = 1; cyc(); key_cq = 0;
    s_lacre   = 1; cyc(); s_lacre   = 0;
    key_lacre = 1; cyc(); key_lacre = 0;
    cyc();
  endtask

  task automatic bottle();
    to_seal();
    s_cq = 1; cyc(); s_cq = 0;
    finish_cq(1'b1);
  endtask

  initial begin
    // ---- reset values
    cyc();
    chk("rst_estado", estado, 0);
    chk("rst_motor", motor, 0);
    chk("rst_rolhas", cont_rolhas, 20);
    chk("rst_estoque", estoque, 10);
    chk("rst_garrafas", cont_garrafas, 0);
    chk("rst_alarme", alarme, 0);
    reset_n = 1'b1;
    cyc();

    // ---- nominal cycle, stepwise
    key_start = 1; cyc(); key_start = 0;
    chk("nom_st1", estado, 1);
    chk("nom_motor1", motor, 1);
    s_ench = 1; cyc(); s_ench = 0;
    chk("nom_st2", estado, 2);
    chk("nom_motor2", motor, 0);
    chk("nom_valv2", valvula, 1);
    s_cheia = 1; cyc(); s_cheia = 0;
    chk("nom_st3", estado, 3);
    chk("nom_valv3", valvula, 0);
    key_vedar = 1; cyc(); key_vedar = 0;
    chk("nom_st4", estado, 4);
    chk("nom_motor4", motor, 1);
    chk("nom_atuador", atuador, 1);
    chk("nom_rolhas", cont_rolhas, 19);
    s_cq = 1; cyc(); s_cq = 0;
    chk("nom_st5", estado, 5);
    chk("nom_motor5", motor, 0);
    chk("nom_atuador_off", atuador, 0);
    sw_ok = 1; key_cq = 1; cyc(); key_cq = 0;
    chk("nom_st6", estado, 6);
    chk("nom_motor6", motor, 1);
    s_lacre = 1; cyc(); s_lacre = 0;
    chk("nom_st7", estado, 7);
    chk("nom_motor7", motor, 0);
    key_lacre = 1; cyc(); key_lacre = 0;
    chk("nom_st0", estado, 0);
    chk("nom_garrafas", cont_garrafas, 1);
    cyc();

    // ---- lot rollover on the 12th bottle
    for (int i = 2; i <= 11; i++) bottle();
    chk("lot_g11", cont_garrafas, 11);
    chk("lot_d0", cont_duzias, 0);
    bottle();
    chk("lot_g0", cont_garrafas, 0);
    chk("lot_d1", cont_duzias, 1);
    chk("lot_rolhas8", cont_rolhas, 8);

    // ---- refill after the seal taking the magazine 5 -> 4
    for (int i = 13; i <= 15; i++) bottle();
    chk("ref_rolhas5", cont_rolhas, 5);
    to_seal();
    chk("ref_rolhas4", cont_rolhas, 4);
    chk("ref_est10", estoque, 10);
    chk("ref_disp_pre", dispensador, 0);
    s_cq = 1; cyc(); s_cq = 0;
    chk("ref_rolhas20", cont_rolhas, 20);
    chk("ref_est9", estoque, 9);
    chk("ref_disp", dispensador, 1);
    sw_ok = 1; key_cq = 1; cyc(); key_cq = 0;
    chk("ref_disp_off", dispensador, 0);
    s_lacre = 1; cyc(); s_lacre = 0;
    key_lacre = 1; cyc(); key_lacre = 0;
    cyc();

    // ---- add coinciding with refill keeps stock
    do_reset();
    for (int i = 1; i <= 15; i++) bottle();
    to_seal();
    sw_add = 1; s_cq = 1; cyc(); sw_add = 0; s_cq = 0;
    chk("col_rolhas20", cont_rolhas, 20);
    chk("col_est10", estoque, 10);
    sw_add = 1; cyc(); sw_add = 0;
    chk("add_est11", estoque, 11);

    // ---- fill timeout
    do_reset();
    key_start = 1; cyc(); key_start = 0;
    s_ench = 1; cyc(); s_ench = 0;
    tick = 1;
    repeat (49) cyc();
    chk("to_st2_49", estado, 2);
    chk("to_falha_49", falha, 0);
    cyc();
    tick = 0;
    chk("to_st9", estado, 9);
    chk("to_falha", falha, 1);
    chk("to_valv", valvula, 0);
    chk("to_motor", motor, 0);
    key_start = 1; cyc(); key_start = 0;
    chk("to_idle", estado, 0);
    chk("to_rolhas", cont_rolhas, 20);
    chk("to_garrafas", cont_garrafas, 0);
    // full bottle and 50th tick on the same edge: full wins
    key_start = 1; cyc(); key_start = 0;
    s_ench = 1; cyc(); s_ench = 0;
    tick = 1;
    repeat (49) cyc();
    s_cheia = 1; cyc(); s_cheia = 0; tick = 0;
    chk("to_prio_st3", estado, 3);

    // ---- reject path
    do_reset();
    bottle();
    to_seal();
    s_cq = 1; cyc(); s_cq = 0;
    sw_ok = 0; key_cq = 1; cyc(); key_cq = 0;
    chk("rej_st8", estado, 8);
    chk("rej_desc", descarte, 1);
    tick = 1;
    repeat (3) cyc();
    chk("rej_desc3", descarte, 1);
    cyc();
    tick = 0;
    chk("rej_desc_off", descarte, 0);
    chk("rej_idle", estado, 0);
    chk("rej_garrafas", cont_garrafas, 1);

    // ---- asynchronous reset in MOVE_LACRE
    to_seal();
    s_cq = 1; cyc(); s_cq = 0;
    sw_ok = 1; key_cq = 1; cyc(); key_cq = 0;
    chk("ar_st6", estado, 6);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_motor", motor, 0);
    chk("ar_estado", estado, 0);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("ar_garrafas", cont_garrafas, 0);
    chk("ar_rolhas", cont_rolhas, 20);

    // ---- starvation: 180 seals drain 10 boxes and the magazine
    for (int i = 1; i <= 180; i++) bottle();
    chk("stv_rolhas", cont_rolhas, 0);
    chk("stv_est", estoque, 0);
    chk("stv_alarme", alarme, 1);
    key_start = 1; cyc(); key_start = 0;
    chk("stv_start_ign", estado, 0);
    sw_add = 1; cyc(); sw_add = 0;
    cyc();
    chk("stv_rolhas20", cont_rolhas, 20);
    chk("stv_est0", estoque, 0);
    chk("stv_alarme0", alarme, 0);

    // ---- dozen saturation: 99 lots then one more
    do_reset();
    for (int i = 1; i <= 1188; i++) begin
      sw_add = 1; cyc(); sw_add = 0;
      bottle();
    end
    chk("dz_99", cont_duzias, 99);
    chk("dz_g0", cont_garrafas, 0);
    for (int i = 1; i <= 12; i++) begin
      sw_add = 1; cyc(); sw_add = 0;
      bottle();
    end
    chk("dz_sat", cont_duzias, 99);
    chk("dz_sat_g0", cont_garrafas, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
